// File: rtl/count_event_logger_pkg.sv
// Shared types and default sizing for the counter event logger and its trace consumers.
// Entry layout is {count, gap}; GAP_MAX/DROP_MAX are the saturation points at default widths.
package count_event_logger_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_GAP_W  = 16;
    localparam int DEF_DROP_W = 8;

    localparam logic [DEF_GAP_W-1:0]  GAP_MAX  = {DEF_GAP_W{1'b1}};
    localparam logic [DEF_DROP_W-1:0] DROP_MAX = {DEF_DROP_W{1'b1}};

    typedef struct packed {
        logic [DEF_WIDTH-1:0] count;
        logic [DEF_GAP_W-1:0] gap;
    } log_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with registered head, valid and level outputs.
// Latency: a push is visible at the head one cycle later; no empty bypass.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   a_rst,
    input  logic                   clear,
    input  logic                   push,
    input  T                       push_dat,
    input  logic                   pop,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output T                       head,
    output logic                   head_vld
);

    localparam int AW = $clog2(DEPTH);

    T mem [DEPTH];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_nxt;
    logic [AW:0] rd_nxt;
    logic        empty;
    logic        pop_ok;
    logic        push_ok;
    T            head_d;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign wr_nxt  = wr_ptr + (AW+1)'(push_ok);
    assign rd_nxt  = rd_ptr + (AW+1)'(pop_ok);

    // The new head comes from the incoming entry when it lands in the slot being exposed.
    always_comb begin
        head_d = mem[rd_nxt[AW-1:0]];
        if (push_ok && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) begin
            head_d = push_dat;
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head_vld <= 1'b0;
            head     <= '0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            head_vld <= 1'b0;
            head     <= '0;
        end else begin
            wr_ptr   <= wr_nxt;
            rd_ptr   <= rd_nxt;
            level    <= wr_nxt - rd_nxt;
            head_vld <= (wr_nxt != rd_nxt);
            head     <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/count_event_logger.sv
// Logs counter done rising edges as {count, gap} entries and drains them over valid/ready.
// Latency: entry visible one cycle after the event edge. Backpressure: full FIFO drops
// the event (sticky overflow, saturating drop_cnt). COUNT_EVENT_LOGGER_SEQ_CHECK_EN adds seq_err.
module count_event_logger
    import count_event_logger_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int DROP_W = DEF_DROP_W
) (
    input  logic                   clk,
    input  logic                   a_rst,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       count_i,
    input  logic                   done_i,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_count,
    output logic [GAP_W-1:0]       out_gap,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_cnt,
    output logic                   seq_err
);

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic [GAP_W-1:0] gap;
    } entry_t;

    logic       done_q;
    logic       evt;
    logic       pop;
    logic       full;
    logic       drop;
    logic [GAP_W-1:0] gap_cnt;
    entry_t     push_dat;
    entry_t     head;

    assign evt      = done_i && !done_q;
    assign pop      = out_valid && out_ready;
    assign drop     = evt && full && !pop;
    assign push_dat = '{count: count_i, gap: gap_cnt};

    // gap_cnt holds the edges elapsed since the last event (or since reset/clear).
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            done_q  <= 1'b0;
            gap_cnt <= '0;
        end else if (clear) begin
            done_q  <= done_i;
            gap_cnt <= '0;
        end else begin
            done_q <= done_i;
            if (evt) begin
                gap_cnt <= GAP_W'(1);
            end else if (gap_cnt != {GAP_W{1'b1}}) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != {DROP_W{1'b1}}) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    sync_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .a_rst    (a_rst),
        .clear    (clear),
        .push     (evt),
        .push_dat (push_dat),
        .pop      (pop),
        .full     (full),
        .level    (level),
        .head     (head),
        .head_vld (out_valid)
    );

    assign out_count = head.count;
    assign out_gap   = head.gap;

`ifdef COUNT_EVENT_LOGGER_SEQ_CHECK_EN
    logic [WIDTH-1:0] prev_count;
    logic [WIDTH-1:0] prev_inc;
    logic             prev_vld;
    logic             seq_ok;

    // A counter may hold, step by one (with wrap) or restart from zero.
    assign prev_inc = prev_count + WIDTH'(1);
    assign seq_ok   = (count_i == prev_count) || (count_i == prev_inc) || (count_i == '0);

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            prev_count <= '0;
            prev_vld   <= 1'b0;
            seq_err    <= 1'b0;
        end else if (clear) begin
            prev_count <= '0;
            prev_vld   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            prev_count <= count_i;
            prev_vld   <= 1'b1;
            if (prev_vld && !seq_ok) begin
                seq_err <= 1'b1;
            end
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_count_event_logger.sv
// Bench for count_event_logger: directed scenarios plus randomized traffic against a queue model.
module tb_count_event_logger;

    logic        clk = 1'b0;
    logic        a_rst = 1'b1;
    logic        clear = 1'b0;
    logic        done_i = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  count_i = 8'd0;
    logic        out_valid;
    logic [7:0]  out_count;
    logic [15:0] out_gap;
    logic [2:0]  level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        seq_err;

    count_event_logger dut (
        .clk       (clk),
        .a_rst     (a_rst),
        .clear     (clear),
        .count_i   (count_i),
        .done_i    (done_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_gap   (out_gap),
        .level     (level),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .seq_err   (seq_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct { int cnt; int gap; } ent_t;
    ent_t mq[$];
    int   m_prev_done, m_gap, m_ovf, m_drops, m_seq, m_pv, m_pc;

    task automatic model_reset();
        mq.delete();
        m_prev_done = 0; m_gap = 0; m_ovf = 0; m_drops = 0; m_seq = 0; m_pv = 0; m_pc = 0;
    endtask

    // One clock edge of the logger as described behaviourally: queue of {count, gap} records.
    task automatic model_edge();
        bit   ev;
        ent_t e;
        if (clear) begin
            model_reset();
            m_prev_done = done_i;
            return;
        end
        ev = done_i && (m_prev_done == 0);
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (ev) begin
            if (mq.size() < 4) begin
                e.cnt = count_i; e.gap = m_gap; mq.push_back(e);
            end else begin
                m_ovf = 1;
                if (m_drops < 255) m_drops++;
            end
        end
        m_gap = ev ? 1 : ((m_gap < 65535) ? m_gap + 1 : 65535);
        m_prev_done = done_i;
`ifdef COUNT_EVENT_LOGGER_SEQ_CHECK_EN
        if (m_pv != 0 && !(count_i == m_pc || count_i == ((m_pc + 1) % 256) || count_i == 0)) m_seq = 1;
        m_pc = count_i;
        m_pv = 1;
`endif
    endtask

    task automatic step(input bit d, input int c, input bit r, input bit clr);
        done_i = d; count_i = c[7:0]; out_ready = r; clear = clr;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        #2;
        model_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d want 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (out_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", out_count); end
        checks++; if (out_gap !== 16'd0) begin errors++; $display("FAIL reset_gap: got %0d want 0", out_gap); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0d want 0", overflow); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %0d want 0", seq_err); end
        @(negedge clk);
        a_rst = 1'b0;
    endtask

    // Event sampled on the sixth edge after release: five edges elapsed before it.
    task automatic test_first_event();
        int c0, vcnt;
        c0 = $urandom_range(1, 255);
        for (int i = 0; i < 5; i++) step(0, i, 1, 0);
        step(1, c0, 1, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid: got %0d want 1", out_valid); end
        checks++; if (out_count !== c0[7:0]) begin errors++; $display("FAIL first_count: got %0d want %0d", out_count, c0); end
        checks++; if (out_gap !== 16'd5) begin errors++; $display("FAIL first_gap: got %0d want 5", out_gap); end
        vcnt = 1;
        for (int i = 0; i < 5; i++) begin
            step(i < 2, c0, 1, 0);
            if (out_valid === 1'b1) vcnt++;
        end
        checks++; if (vcnt != 1) begin errors++; $display("FAIL first_valid_cycles: got %0d want 1", vcnt); end
    endtask

    task automatic test_overflow();
        int cnts[6];
        step(0, 0, 0, 1);
        for (int p = 0; p < 6; p++) begin
            cnts[p] = $urandom_range(0, 255);
            step(1, cnts[p], 0, 0);
            step(0, 0, 0, 0);
            step(0, 0, 0, 0);
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0d want 1", overflow); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid%0d: got %0d want 1", i, out_valid); end
            checks++; if (out_count !== cnts[i][7:0]) begin errors++; $display("FAIL ovf_drain_count%0d: got %0d want %0d", i, out_count, cnts[i]); end
            // The first event lands on the edge right after clear, so no edges preceded it.
            checks++; if (out_gap !== ((i == 0) ? 16'd0 : 16'd3)) begin errors++; $display("FAIL ovf_drain_gap%0d: got %0d want %0d", i, out_gap, (i == 0) ? 0 : 3); end
            step(0, 0, 1, 0);
        end
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL ovf_drained: got valid=%0d level=%0d want 0/0", out_valid, level); end
    endtask

    task automatic test_full_pop();
        int cnts[4];
        int cx, last_cnt, last_gap;
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cnts[i] = $urandom_range(0, 255);
            step(1, cnts[i], 0, 0);
            step(0, 0, 0, 0);
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_fill: got %0d want 4", level); end
        cx = $urandom_range(0, 255);
        step(1, cx, 1, 0);
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level: got %0d want 4", level); end
        checks++; if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin errors++; $display("FAIL fullpop_drop: got drop=%0d ovf=%0d want 0/0", drop_cnt, overflow); end
        last_cnt = -1; last_gap = -1;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                checks++; if (out_count !== cnts[i + 1][7:0]) begin errors++; $display("FAIL fullpop_order%0d: got %0d want %0d", i, out_count, cnts[i + 1]); end
            end
            last_cnt = out_count; last_gap = out_gap;
            step(0, 0, 1, 0);
        end
        checks++; if (last_cnt != cx) begin errors++; $display("FAIL fullpop_last_count: got %0d want %0d", last_cnt, cx); end
        checks++; if (last_gap != 2) begin errors++; $display("FAIL fullpop_last_gap: got %0d want 2", last_gap); end
    endtask

    task automatic test_reset_mid_drain();
        int c;
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, i + 10, 0, 0);
            step(0, 0, 0, 0);
        end
        checks++; if (level !== 3'd3) begin errors++; $display("FAIL rst_mid_fill: got %0d want 3", level); end
        out_ready = 1'b1;
        done_i = 1'b1;
        #2;
        a_rst = 1'b1;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0d want 0", out_valid); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_mid_level: got %0d want 0", level); end
        @(posedge clk);
        @(negedge clk);
        a_rst = 1'b0;
        c = $urandom_range(0, 255);
        step(1, c, 1, 0);
        checks++; if (out_valid !== 1'b1 || level !== 3'd1) begin errors++; $display("FAIL rst_rel_entry: got valid=%0d level=%0d want 1/1", out_valid, level); end
        checks++; if (out_count !== c[7:0] || out_gap !== 16'd0) begin errors++; $display("FAIL rst_rel_data: got %0d/%0d want %0d/0", out_count, out_gap, c); end
        step(1, c, 1, 0);
        checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL rst_rel_single: got valid=%0d level=%0d want 0/0", out_valid, level); end
    endtask

    task automatic test_seq();
        int vals[6];
        vals = '{3, 4, 4, 0, 1, 7};
        step(0, 0, 0, 1);
`ifdef COUNT_EVENT_LOGGER_SEQ_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            step(0, vals[i], 0, 0);
            checks++; if (seq_err !== (i == 5)) begin errors++; $display("FAIL seq_bad%0d: got %0d want %0d", i, seq_err, i == 5); end
        end
        step(0, 0, 0, 1);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_clear: got %0d want 0", seq_err); end
        step(0, 255, 0, 0);
        step(0, 0, 0, 0);
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_wrap: got %0d want 0", seq_err); end
`else
        for (int i = 0; i < 6; i++) begin
            step(0, vals[i], 0, 0);
            checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_tied%0d: got %0d want 0", i, seq_err); end
        end
`endif
    endtask

    task automatic test_random();
        bit d, r, clr;
        step(0, 0, 0, 1);
        for (int i = 0; i < 600; i++) begin
            d   = ($urandom % 4) == 0;
            r   = ((i / 64) % 2 == 1) ? (($urandom % 5) == 0) : (($urandom % 3) != 0);
            clr = ($urandom % 150) == 0;
            step(d, $urandom_range(0, 255), r, clr);
            checks++; if (out_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %0d want %0d", i, out_valid, mq.size() > 0); end
            checks++; if (level !== 3'(mq.size())) begin errors++; $display("FAIL rnd_level@%0d: got %0d want %0d", i, level, mq.size()); end
            checks++; if (overflow !== m_ovf[0] || drop_cnt !== m_drops[7:0]) begin errors++; $display("FAIL rnd_drop@%0d: got %0d/%0d want %0d/%0d", i, overflow, drop_cnt, m_ovf, m_drops); end
            checks++; if (seq_err !== m_seq[0]) begin errors++; $display("FAIL rnd_seq@%0d: got %0d want %0d", i, seq_err, m_seq); end
            if (mq.size() > 0) begin
                checks++; if (out_count !== mq[0].cnt[7:0] || out_gap !== mq[0].gap[15:0]) begin errors++; $display("FAIL rnd_head@%0d: got %0d/%0d want %0d/%0d", i, out_count, out_gap, mq[0].cnt, mq[0].gap); end
            end
        end
    endtask

    task automatic test_gap_sat();
        int c;
        step(0, 0, 0, 1);
        for (int i = 0; i < 70000; i++) step(0, 0, 0, 0);
        c = $urandom_range(0, 255);
        step(1, c, 0, 0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gapsat_valid: got %0d want 1", out_valid); end
        checks++; if (out_gap !== 16'd65535) begin errors++; $display("FAIL gapsat_gap: got %0d want 65535", out_gap); end
        checks++; if (out_count !== c[7:0]) begin errors++; $display("FAIL gapsat_count: got %0d want %0d", out_count, c); end
    endtask

    initial begin
        test_reset();
        test_first_event();
        test_overflow();
        test_full_pop();
        test_reset_mid_drain();
        test_seq();
        test_random();
        test_gap_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
